// File: rtl/pulse_to_lvl_hs_if.sv
// Handshake bundle for pulse_to_lvl_hs: local event side plus
// the REQ/ACK level pair toward the consumer.
interface pulse_to_lvl_hs_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 PULSE_IN;
    logic                 ACK_IN;
    logic                 CLR_ERR;
    logic                 LVL_OUT;
    logic                 BUSY;
    logic [CNT_WIDTH-1:0] PEND_CNT;
    logic                 OVERFLOW;
    logic                 TIMEOUT_ERR;

    modport master (
        output PULSE_IN, ACK_IN, CLR_ERR,
        input  LVL_OUT, BUSY, PEND_CNT, OVERFLOW, TIMEOUT_ERR
    );

    modport slave (
        input  PULSE_IN, ACK_IN, CLR_ERR,
        output LVL_OUT, BUSY, PEND_CNT, OVERFLOW, TIMEOUT_ERR
    );
endinterface

// File: rtl/pulse_to_lvl_hs.sv
// Pulse to four-phase level handshake with event queueing,
// saturation reporting and per-phase timeout abort.
module pulse_to_lvl_hs #(
    parameter int CNT_WIDTH = 4,
    parameter int TO_WIDTH  = 8,
    parameter int TIMEOUT   = 200
) (
    input logic              CLK,
    input logic              RST,
    pulse_to_lvl_hs_if.slave hs
);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_e;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 lvl_q, lvl_d;
    logic                 ovf_q, ovf_d;
    logic                 to_err_q, to_err_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic [TO_WIDTH-1:0]  tcnt_q, tcnt_d;
    logic                 launch;
    logic                 expired;
    logic                 queue_evt;

    assign expired   = (tcnt_q == TO_LAST);
    assign launch    = (state_q == IDLE) && !hs.ACK_IN &&
                       (hs.PULSE_IN || (pend_q != '0));
    // A pulse that launches directly is not queued
    assign queue_evt = hs.PULSE_IN && !launch;

    always_comb begin
        state_d  = state_q;
        to_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = REQ;
            end
            REQ: begin
                if (hs.ACK_IN) begin
                    state_d = REL;
                end else if (expired) begin
                    state_d  = IDLE;
                    to_err_d = 1'b1;
                end
            end
            REL: begin
                if (!hs.ACK_IN) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d  = IDLE;
                    to_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q & ~hs.CLR_ERR;
        if (launch && !hs.PULSE_IN) begin
            pend_d = pend_q - 1'b1;
        end else if (queue_evt) begin
            if (&pend_q) ovf_d  = 1'b1;
            else         pend_d = pend_q + 1'b1;
        end
    end

    always_comb begin
        if ((state_d != state_q) || (state_q == IDLE)) tcnt_d = '0;
        else                                           tcnt_d = tcnt_q + 1'b1;
        lvl_d = (state_d == REQ);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            lvl_q    <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            to_err_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            to_err_q <= to_err_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign hs.LVL_OUT     = lvl_q;
    assign hs.BUSY        = (state_q != IDLE);
    assign hs.PEND_CNT    = pend_q;
    assign hs.OVERFLOW    = ovf_q;
    assign hs.TIMEOUT_ERR = to_err_q;
endmodule

// File: tb/tb_pulse_to_lvl_hs.sv
// Bench for pulse_to_lvl_hs: directed table, corner sequences and
// random traffic against a behavioural handshake model.
module tb_pulse_to_lvl_hs;
    localparam int CW   = 4;
    localparam int TW   = 8;
    localparam int TO   = 200;
    localparam int MAXP = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pulse_to_lvl_hs_if #(.CNT_WIDTH(CW)) hs ();

    pulse_to_lvl_hs #(
        .CNT_WIDTH(CW),
        .TO_WIDTH (TW),
        .TIMEOUT  (TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .hs (hs)
    );

    typedef struct {
        bit rst, p, a, c;
        bit lvl, busy;
        int pend;
        bit ovf, to;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: phase 0=idle 1=request high 2=release; age = cycles in phase
    int m_ph, m_age, m_pend;
    bit m_ovf, m_to;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit p, bit a, bit c);
        int nxt;
        bit used;
        bit set;
        if (r) begin
            m_ph = 0; m_age = 1; m_pend = 0; m_ovf = 0; m_to = 0;
            return;
        end
        nxt  = m_ph;
        used = 0;
        set  = 0;
        m_to = 0;
        if (m_ph == 0) begin
            if (!a && (p || m_pend > 0)) begin
                nxt = 1;
                if (p) used = 1;
                else   m_pend = m_pend - 1;
            end
        end else begin
            bit done = (m_ph == 1) ? a : !a;
            if (done)                nxt = (m_ph == 1) ? 2 : 0;
            else if (m_age >= TO) begin nxt = 0; m_to = 1; end
        end
        if (p && !used) begin
            if (m_pend >= MAXP) set = 1;
            else                m_pend = m_pend + 1;
        end
        if (set)    m_ovf = 1;
        else if (c) m_ovf = 0;
        m_age = (nxt != m_ph) ? 1 : m_age + 1;
        m_ph  = nxt;
    endtask

    task automatic step(bit r, bit p, bit a, bit c);
        @(negedge CLK);
        RST = r; hs.PULSE_IN = p; hs.ACK_IN = a; hs.CLR_ERR = c;
        @(posedge CLK);
        model_step(r, p, a, c);
        #1;
        chk("m_lvl",  hs.LVL_OUT,     32'(m_ph == 1));
        chk("m_busy", hs.BUSY,        32'(m_ph != 0));
        chk("m_pend", hs.PEND_CNT,    m_pend);
        chk("m_ovf",  hs.OVERFLOW,    m_ovf);
        chk("m_to",   hs.TIMEOUT_ERR, m_to);
    endtask

    initial begin
        int rises, bad_gap, low_run, k;
        bit a, prev;
        RST = 1; hs.PULSE_IN = 0; hs.ACK_IN = 0; hs.CLR_ERR = 0;

        //            rst p a c lvl busy pend ovf to
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].p, tbl[i].a, tbl[i].c);
            chk("t_lvl",  hs.LVL_OUT,     tbl[i].lvl);
            chk("t_busy", hs.BUSY,        tbl[i].busy);
            chk("t_pend", hs.PEND_CNT,    tbl[i].pend);
            chk("t_ovf",  hs.OVERFLOW,    tbl[i].ovf);
            chk("t_to",   hs.TIMEOUT_ERR, tbl[i].to);
        end

        // Queued events replayed with a responsive consumer
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("q_pend3", hs.PEND_CNT, 3);
        rises = 1; bad_gap = 0; low_run = 0; prev = 1;
        for (int i = 0; i < 80; i++) begin
            a = hs.LVL_OUT;
            step(0, 0, a, 0);
            if (hs.LVL_OUT && !prev) begin
                rises++;
                if (low_run < 2) bad_gap++;
            end
            low_run = hs.LVL_OUT ? 0 : low_run + 1;
            prev = hs.LVL_OUT;
        end
        chk("q_rises", rises, 4);
        chk("q_gap",   bad_gap, 0);
        chk("q_pend0", hs.PEND_CNT, 0);
        chk("q_idle",  hs.BUSY, 0);

        // Saturation and sticky overflow
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("s_pend", hs.PEND_CNT, 15);
        chk("s_ovf",  hs.OVERFLOW, 1);
        step(0, 1, 0, 1);
        chk("s_setwin", hs.OVERFLOW, 1);
        step(0, 0, 0, 1);
        chk("s_clr", hs.OVERFLOW, 0);
        step(1, 0, 0, 0);

        // Reset in REQ with five pending events
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("r_pend5", hs.PEND_CNT, 5);
        chk("r_lvl1",  hs.LVL_OUT, 1);
        step(1, 0, 0, 0);
        chk("r_lvl",  hs.LVL_OUT, 0);
        chk("r_pend", hs.PEND_CNT, 0);
        chk("r_busy", hs.BUSY, 0);
        chk("r_ovf",  hs.OVERFLOW, 0);
        step(0, 0, 0, 0);

        // Timeout with no acknowledge
        step(0, 1, 0, 0);
        k = 1;
        while (k < 300 && !hs.TIMEOUT_ERR) begin
            step(0, 0, 0, 0);
            k++;
        end
        chk("to_delay", k - 1, 200);
        chk("to_lvl",   hs.LVL_OUT, 0);
        step(0, 0, 0, 0);
        chk("to_pulse", hs.TIMEOUT_ERR, 0);

        // Acknowledge on the final allowed REQ cycle
        step(0, 1, 0, 0);
        for (int i = 0; i < 199; i++) step(0, 0, 0, 0);
        chk("la_lvl", hs.LVL_OUT, 1);
        step(0, 0, 1, 0);
        chk("la_rel",  hs.BUSY, 1);
        chk("la_lvl0", hs.LVL_OUT, 0);
        chk("la_err",  hs.TIMEOUT_ERR, 0);
        step(0, 0, 0, 0);

        // Random traffic against the model
        a = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) != 0) a = (m_ph == 1);
            step($urandom_range(299) == 0,
                 $urandom_range(2) == 0,
                 a,
                 $urandom_range(19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
